// File: rtl/busio.sv
// busio: shares one external bus between instruction fetch and load/store.
//
// The fetch side is served from a one-entry latch. The memory side is served
// from a completion record of the last memory transaction. A bus transaction
// is issued only when the current request misses. Memory wins when both miss.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   fetch_address/data/ready   instruction fetch port (word address in)
//   mem_address, mem_store_data, mem_size, mem_signed,
//   mem_load, mem_store        load/store request (held while mem_ready low)
//   mem_load_data, mem_ready   load result and completion
//   ext_address, ext_write_data, ext_write_strobe,
//   ext_instruction, ext_valid registered external bus request
//   ext_ready, ext_read_data   external bus completion and read word
//
// state | meaning
// IDLE  | no transaction in flight; arbitrate misses
// FETCH | instruction read in flight, waiting for ext_ready
// MEM   | load or store in flight, waiting for ext_ready
module busio (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        mem_load,
    input  logic        mem_store,
    output logic [31:0] mem_load_data,
    output logic        mem_ready,
    output logic [31:0] ext_address,
    output logic [31:0] ext_write_data,
    output logic [3:0]  ext_write_strobe,
    output logic        ext_instruction,
    output logic        ext_valid,
    input  logic        ext_ready,
    input  logic [31:0] ext_read_data
);
    typedef enum logic [1:0] {IDLE, FETCH, MEM} state_t;
    state_t state;

    logic        fl_valid;
    logic [31:0] fl_address;
    logic [31:0] fl_data;
    logic [31:0] fetch_issued;

    logic        rec_valid;
    logic [31:0] rec_address;
    logic [1:0]  rec_size;
    logic        rec_signed;
    logic        rec_store;
    logic [31:0] rec_store_data;
    logic [31:0] rec_load_data;

    logic        mem_request;
    logic        rec_match;
    logic [3:0]  lane_strobe;
    logic [31:0] lane_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;

    assign mem_request = mem_load | mem_store;

    // Store data only matters for stores; a load hit ignores it.
    assign rec_match = rec_valid
                    && rec_address == mem_address
                    && rec_size == mem_size
                    && rec_signed == mem_signed
                    && rec_store == mem_store
                    && (!mem_store || rec_store_data == mem_store_data);

    assign mem_ready     = !mem_request || rec_match;
    assign mem_load_data = rec_load_data;
    assign fetch_ready   = fl_valid && fl_address == fetch_address;
    assign fetch_data    = fl_data;

    always_comb begin
        lane_strobe = 4'b1111;
        lane_data   = mem_store_data;
        case (mem_address[1:0])
            2'd0:    load_byte = ext_read_data[7:0];
            2'd1:    load_byte = ext_read_data[15:8];
            2'd2:    load_byte = ext_read_data[23:16];
            default: load_byte = ext_read_data[31:24];
        endcase
        load_half  = mem_address[1] ? ext_read_data[31:16] : ext_read_data[15:0];
        load_value = ext_read_data;
        case (mem_size)
            2'd0: begin
                lane_strobe = 4'b0001 << mem_address[1:0];
                lane_data   = {4{mem_store_data[7:0]}};
                load_value  = {{24{mem_signed & load_byte[7]}}, load_byte};
            end
            2'd1: begin
                lane_strobe = mem_address[1] ? 4'b1100 : 4'b0011;
                lane_data   = {2{mem_store_data[15:0]}};
                load_value  = {{16{mem_signed & load_half[15]}}, load_half};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            ext_valid        <= 1'b0;
            ext_address      <= 32'h0;
            ext_write_data   <= 32'h0;
            ext_write_strobe <= 4'b0000;
            ext_instruction  <= 1'b0;
            fl_valid         <= 1'b0;
            fl_address       <= 32'h0;
            fl_data          <= 32'h0;
            fetch_issued     <= 32'h0;
            rec_valid        <= 1'b0;
            rec_address      <= 32'h0;
            rec_size         <= 2'd0;
            rec_signed       <= 1'b0;
            rec_store        <= 1'b0;
            rec_store_data   <= 32'h0;
            rec_load_data    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_request && !rec_match) begin
                        state            <= MEM;
                        ext_valid        <= 1'b1;
                        ext_address      <= {mem_address[31:2], 2'b00};
                        ext_instruction  <= 1'b0;
                        ext_write_strobe <= mem_store ? lane_strobe : 4'b0000;
                        ext_write_data   <= mem_store ? lane_data : 32'h0;
                    end else if (!fetch_ready) begin
                        state            <= FETCH;
                        ext_valid        <= 1'b1;
                        ext_address      <= {fetch_address[31:2], 2'b00};
                        ext_instruction  <= 1'b1;
                        ext_write_strobe <= 4'b0000;
                        ext_write_data   <= 32'h0;
                        // Latched under this address even if fetch moves on.
                        fetch_issued     <= fetch_address;
                    end
                end
                FETCH: begin
                    if (ext_ready) begin
                        state      <= IDLE;
                        ext_valid  <= 1'b0;
                        fl_valid   <= 1'b1;
                        fl_address <= fetch_issued;
                        fl_data    <= ext_read_data;
                    end
                end
                MEM: begin
                    if (ext_ready) begin
                        state          <= IDLE;
                        ext_valid      <= 1'b0;
                        rec_valid      <= 1'b1;
                        rec_address    <= mem_address;
                        rec_size       <= mem_size;
                        rec_signed     <= mem_signed;
                        rec_store      <= mem_store;
                        rec_store_data <= mem_store_data;
                        rec_load_data  <= load_value;
                        // A store into the latched instruction word makes it stale.
                        if (mem_store && fl_address[31:2] == mem_address[31:2])
                            fl_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_busio.sv
module tb_busio;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_address;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic [31:0] mem_address;
    logic [31:0] mem_store_data;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_load_data;
    logic        mem_ready;
    logic [31:0] ext_address;
    logic [31:0] ext_write_data;
    logic [3:0]  ext_write_strobe;
    logic        ext_instruction;
    logic        ext_valid;
    logic        ext_ready;
    logic [31:0] ext_read_data;

    busio dut (
        .clk(clk), .reset(reset),
        .fetch_address(fetch_address), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
        .mem_address(mem_address), .mem_store_data(mem_store_data), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_load(mem_load), .mem_store(mem_store),
        .mem_load_data(mem_load_data), .mem_ready(mem_ready),
        .ext_address(ext_address), .ext_write_data(ext_write_data),
        .ext_write_strobe(ext_write_strobe), .ext_instruction(ext_instruction),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_read_data(ext_read_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus-side memory (written by the DUT's stores) and the reference byte memory.
    logic [31:0] bus_mem [0:511];
    logic [7:0]  ref_mem [0:2047];

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        bus_mem[a[10:2]] = w;
        for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = 8'(w >> (8 * i));
    endtask

    function automatic int nb(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic sg);
        int n = nb(s);
        int base = int'(a) - int'(a) % n;
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[base + i]) << (8 * i);
        if (sg && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strobe(input logic [31:0] a, input logic [1:0] s);
        int n = nb(s);
        int off = int'(a[1:0]);
        logic [3:0] st = 4'b0000;
        off -= off % n;
        for (int i = 0; i < n; i++) st[off + i] = 1'b1;
        return st;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] s, input logic [31:0] d);
        int n = nb(s);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++) w[8 * k +: 8] = 8'(d >> (8 * (k % n)));
        return w;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int n = nb(s);
        int base = int'(a) - int'(a) % n;
        for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(d >> (8 * i));
    endtask

    // External bus slave with configurable response delay.
    int          fixed_delay = 0;
    int          mem_cnt = 0;
    int          fetch_cnt = 0;
    logic        pending = 1'b0;
    int          wait_left = 0;
    logic [63:0] cap_aw;
    logic [4:0]  cap_si;
    logic [31:0] last_mem_addr, last_mem_wdata, last_fetch_addr;
    logic [3:0]  last_mem_strobe;

    initial begin
        ext_ready = 1'b0;
        ext_read_data = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ext_ready = 1'b0;
                pending = 1'b0;
            end else if (ext_ready) begin
                ext_ready = 1'b0;
                pending = 1'b0;
                ext_read_data = $urandom;
                check_eq("valid_drop", 64'(ext_valid), 64'd0);
            end else if (ext_valid) begin
                if (!pending) begin
                    pending = 1'b1;
                    cap_aw = {ext_address, ext_write_data};
                    cap_si = {ext_write_strobe, ext_instruction};
                    wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                    check_eq("addr_align", 64'(ext_address[1:0]), 64'd0);
                end else begin
                    check_eq("stable_addr_data", {ext_address, ext_write_data}, cap_aw);
                    check_eq("stable_strb_instr", 64'({ext_write_strobe, ext_instruction}), 64'(cap_si));
                end
                if (wait_left == 0) begin
                    ext_ready = 1'b1;
                    ext_read_data = bus_mem[ext_address[10:2]];
                    for (int k = 0; k < 4; k++)
                        if (ext_write_strobe[k]) bus_mem[ext_address[10:2]][8 * k +: 8] = ext_write_data[8 * k +: 8];
                    if (ext_instruction) begin
                        fetch_cnt++;
                        last_fetch_addr = ext_address;
                    end else begin
                        mem_cnt++;
                        last_mem_addr = ext_address;
                        last_mem_strobe = ext_write_strobe;
                        last_mem_wdata = ext_write_data;
                    end
                end else begin
                    wait_left--;
                end
            end else begin
                ext_read_data = $urandom;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        #1;
        while (!(fetch_ready && mem_ready) && k < 200) begin
            step();
            k++;
        end
        check_eq(tag, 64'(fetch_ready && mem_ready), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!ext_valid && k < 50) begin
            step();
            k++;
        end
        check_eq(tag, 64'(ext_valid), 64'd1);
    endtask

    // Reference state for the random phase.
    logic        m_rec_valid, m_sg, m_st, m_fl_valid;
    logic [31:0] m_addr, m_data, m_fl_addr;
    logic [1:0]  m_size;
    logic        req, hit, exp_mem, exp_fetch, fl_v;
    int          c0m, c0f, n, kind;

    initial begin
        fetch_address = 32'h100;
        mem_address = 32'h0;
        mem_store_data = 32'h0;
        mem_size = 2'd0;
        mem_signed = 1'b0;
        mem_load = 1'b0;
        mem_store = 1'b0;
        for (int w = 0; w < 512; w++) preload(32'(w * 4), $urandom);
        preload(32'h100, 32'h00000013);
        preload(32'h200, 32'h80FFFFFF);

        // Reset state
        step(); step(); step();
        check_eq("rst_valid", 64'(ext_valid), 64'd0);
        check_eq("rst_strobe", 64'(ext_write_strobe), 64'd0);
        check_eq("rst_instr", 64'(ext_instruction), 64'd0);
        check_eq("rst_addr", 64'(ext_address), 64'd0);
        check_eq("rst_wdata", 64'(ext_write_data), 64'd0);
        check_eq("rst_fetch_ready", 64'(fetch_ready), 64'd0);
        check_eq("rst_mem_ready_idle", 64'(mem_ready), 64'd1);
        mem_load = 1'b1;
        #1;
        check_eq("rst_mem_ready_req", 64'(mem_ready), 64'd0);
        mem_load = 1'b0;

        // Fetch miss, minimum latency
        fixed_delay = 0;
        step();
        reset = 1'b0;
        step();
        check_eq("fm_valid", 64'(ext_valid), 64'd1);
        check_eq("fm_addr", 64'(ext_address), 64'h100);
        check_eq("fm_instr", 64'(ext_instruction), 64'd1);
        step();
        check_eq("fm_valid_1cyc", 64'(ext_valid), 64'd0);
        check_eq("fm_ready", 64'(fetch_ready), 64'd1);
        check_eq("fm_data", 64'(fetch_data), 64'h13);

        // Signed / unsigned byte load
        fixed_delay = 1;
        mem_address = 32'h203; mem_size = 2'd0; mem_signed = 1'b1; mem_load = 1'b1;
        wait_valid("ldb_valid");
        check_eq("ldb_strobe", 64'(ext_write_strobe), 64'd0);
        check_eq("ldb_addr", 64'(ext_address), 64'h200);
        wait_ready("ldb_ready_s");
        check_eq("ldb_signed", 64'(mem_load_data), 64'hFFFFFF80);
        mem_signed = 1'b0;
        wait_ready("ldb_ready_u");
        check_eq("ldb_unsigned", 64'(mem_load_data), 64'h00000080);
        step();
        mem_load = 1'b0;

        // Half store, issued once
        mem_address = 32'h402; mem_size = 2'd1; mem_store_data = 32'h0000BEEF; mem_store = 1'b1;
        c0m = mem_cnt;
        wait_valid("sth_valid");
        check_eq("sth_strobe", 64'(ext_write_strobe), 64'b1100);
        check_eq("sth_wdata", 64'(ext_write_data), 64'hBEEFBEEF);
        check_eq("sth_addr", 64'(ext_address), 64'h400);
        wait_ready("sth_ready");
        repeat (5) step();
        check_eq("sth_ready_held", 64'(mem_ready), 64'd1);
        check_eq("sth_once", 64'(mem_cnt - c0m), 64'd1);
        model_store(32'h402, 2'd1, 32'h0000BEEF);
        mem_store = 1'b0;

        // Arbitration with stalled ext_ready
        fixed_delay = 3;
        fetch_address = 32'h104;
        mem_address = 32'h208; mem_size = 2'd2; mem_signed = 1'b0; mem_load = 1'b1;
        step();
        wait_valid("arb_mem_valid");
        check_eq("arb_mem_first", 64'(ext_instruction), 64'd0);
        check_eq("arb_mem_addr", 64'(ext_address), 64'h208);
        n = 0;
        while (ext_valid && n < 20) begin step(); n++; end
        check_eq("arb_valid_cycles", 64'(n), 64'd4);
        wait_valid("arb_fetch_valid");
        check_eq("arb_fetch_instr", 64'(ext_instruction), 64'd1);
        check_eq("arb_fetch_addr", 64'(ext_address), 64'h104);
        wait_ready("arb_ready");
        check_eq("arb_load_data", 64'(mem_load_data), 64'(model_load(32'h208, 2'd2, 1'b0)));
        check_eq("arb_fetch_data", 64'(fetch_data), 64'(model_load(32'h104, 2'd2, 1'b0)));
        mem_load = 1'b0;

        // Fetch address changes mid-transaction
        fixed_delay = 2;
        fetch_address = 32'h110;
        step();
        wait_valid("br_valid");
        step();
        fetch_address = 32'h114;
        c0f = fetch_cnt;
        n = 0;
        while (ext_valid && n < 20) begin step(); n++; end
        check_eq("br_stale_not_ready", 64'(fetch_ready), 64'd0);
        wait_ready("br_ready");
        check_eq("br_fetches", 64'(fetch_cnt - c0f), 64'd2);
        check_eq("br_last_addr", 64'(last_fetch_addr), 64'h114);
        check_eq("br_data", 64'(fetch_data), 64'(model_load(32'h114, 2'd2, 1'b0)));

        // Store coherence
        fixed_delay = -1;
        fetch_address = 32'h300;
        wait_ready("coh_fetch");
        mem_address = 32'h300; mem_size = 2'd2; mem_store_data = 32'hCAFEF00D; mem_store = 1'b1;
        c0f = fetch_cnt;
        wait_ready("coh_ready");
        check_eq("coh_refetch", 64'(fetch_cnt - c0f), 64'd1);
        check_eq("coh_refetch_addr", 64'(last_fetch_addr), 64'h300);
        check_eq("coh_data", 64'(fetch_data), 64'hCAFEF00D);
        model_store(32'h300, 2'd2, 32'hCAFEF00D);
        mem_store = 1'b0;

        // Reset mid-FETCH
        fixed_delay = 3;
        fetch_address = 32'h10C;
        step();
        wait_valid("rstf_valid");
        step();
        #1;
        reset = 1'b1;
        #1;
        check_eq("rstf_valid_async", 64'(ext_valid), 64'd0);
        check_eq("rstf_addr_async", 64'(ext_address), 64'd0);
        check_eq("rstf_fetch_ready", 64'(fetch_ready), 64'd0);
        step(); step();
        c0f = fetch_cnt;
        fixed_delay = -1;
        reset = 1'b0;
        wait_ready("rstf_ready");
        check_eq("rstf_refetch", 64'(fetch_cnt - c0f), 64'd1);
        check_eq("rstf_addr", 64'(last_fetch_addr), 64'h10C);
        check_eq("rstf_data", 64'(fetch_data), 64'(model_load(32'h10C, 2'd2, 1'b0)));

        // Random operations against the reference model
        m_rec_valid = 1'b0; m_fl_valid = 1'b1; m_fl_addr = 32'h10C;
        m_addr = 32'h0; m_data = 32'h0; m_size = 2'd0; m_sg = 1'b0; m_st = 1'b0;
        for (int op = 0; op < 200; op++) begin
            step();
            if ($urandom_range(0, 1) == 1) fetch_address = 32'h300 + 32'(4 * $urandom_range(0, 15));
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                mem_load = 1'b0;
                mem_store = 1'b0;
            end else if (kind == 1) begin
                if (mem_load) mem_store_data = $urandom;
            end else begin
                mem_store = 1'($urandom_range(0, 1));
                mem_load = !mem_store;
                mem_address = 32'h300 + 32'($urandom_range(0, 63));
                mem_size = 2'($urandom_range(0, 3));
                mem_signed = 1'($urandom_range(0, 1));
                mem_store_data = $urandom;
            end
            req = mem_load | mem_store;
            hit = m_rec_valid && m_addr == mem_address && m_size == mem_size && m_sg == mem_signed
                  && m_st == mem_store && (mem_load || m_data == mem_store_data);
            exp_mem = req && !hit;
            fl_v = m_fl_valid;
            if (exp_mem && mem_store && m_fl_addr[31:2] == mem_address[31:2]) fl_v = 1'b0;
            exp_fetch = !(fl_v && m_fl_addr == fetch_address);
            c0m = mem_cnt;
            c0f = fetch_cnt;
            wait_ready("rnd_ready");
            check_eq("rnd_mem_txns", 64'(mem_cnt - c0m), 64'(exp_mem));
            check_eq("rnd_fetch_txns", 64'(fetch_cnt - c0f), 64'(exp_fetch));
            if (exp_mem) begin
                check_eq("rnd_mem_addr", 64'(last_mem_addr), 64'({mem_address[31:2], 2'b00}));
                check_eq("rnd_strobe", 64'(last_mem_strobe),
                         64'(mem_store ? model_strobe(mem_address, mem_size) : 4'b0000));
                if (mem_store)
                    check_eq("rnd_wdata", 64'(last_mem_wdata), 64'(model_wdata(mem_size, mem_store_data)));
            end
            if (mem_store) model_store(mem_address, mem_size, mem_store_data);
            if (mem_load)
                check_eq("rnd_load_data", 64'(mem_load_data), 64'(model_load(mem_address, mem_size, mem_signed)));
            check_eq("rnd_fetch_data", 64'(fetch_data), 64'(model_load(fetch_address, 2'd2, 1'b0)));
            if (exp_mem) begin
                m_rec_valid = 1'b1; m_addr = mem_address; m_size = mem_size;
                m_sg = mem_signed; m_st = mem_store; m_data = mem_store_data;
            end
            m_fl_valid = 1'b1;
            m_fl_addr = fetch_address;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/busio.md
BUSIO -- requirements
Module: busio

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 fetch_address  in  32  instruction word address from fetch; held stable while fetch_ready is low.
REQ-005 fetch_data  out  32  instruction word for fetch_address; valid while fetch_ready is high.
REQ-006 fetch_ready  out  1  high when fetch_data matches the current fetch_address.
REQ-007 mem_address  in  32  load/store byte address from the memory stage.
REQ-008 mem_store_data  in  32  store data, right-aligned.
REQ-009 mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-010 mem_signed  in  1  sign-extend load data when high.
REQ-011 mem_load, mem_store  in  1 each  access request; never both high; held stable while mem_ready is low.
REQ-012 mem_load_data  out  32  extended load result; valid while mem_ready is high.
REQ-013 mem_ready  out  1  high when no access is requested or the requested access has completed.
REQ-014 ext_address  out  32  word-aligned external bus address (bits [1:0] = 0).
REQ-015 ext_write_data  out  32  store data, lane-aligned.
REQ-016 ext_write_strobe  out  4  byte enables; 0 means read.
REQ-017 ext_instruction  out  1  high when the current transaction is a fetch.
REQ-018 ext_valid  out  1  transaction request.
REQ-019 ext_ready  in  1  transaction complete; ext_read_data is valid in the same cycle.
REQ-020 ext_read_data  in  32  read word.

Function
REQ-021 External bus rules:
- ext_valid, ext_address, ext_write_data, ext_write_strobe and ext_instruction are registered.
- All of them are held stable from ext_valid rise until the cycle ext_ready is sampled high.
- ext_valid drops on the following edge.
- ext_valid is never re-asserted in the same cycle a transaction completes.
REQ-022 FSM states: IDLE, FETCH, MEM.
- IDLE -> MEM when a memory access is requested and it does not match the completion record.
- Otherwise IDLE -> FETCH when the fetch latch misses.
- MEM or FETCH -> IDLE on the edge where ext_ready is sampled high.
REQ-023 Arbitration: memory has priority over fetch when both miss in the same IDLE cycle.
REQ-024 Fetch latch contents: valid bit, address, data.
- Loaded on FETCH completion with the address that was issued.
- fetch_ready = latch valid AND latch address == fetch_address (combinational).
- fetch_data = latch data.
REQ-025 Fetch address change mid-transaction (e.g. branch): the in-flight transaction completes and is latched under its old address; fetch_ready stays low and a new FETCH follows.
REQ-026 Memory completion record contents: valid bit, address, size, signed, load/store kind, store data, extended load result.
- Loaded on MEM completion.
- mem_ready = no request OR (record valid AND all recorded fields equal the current inputs).
- For loads, the store-data field is excluded from the comparison.
REQ-027 Consecutive identical stores (same address, size and data) complete once; this is acceptable because they are idempotent.
REQ-028 Store lanes, with a = mem_address[1:0]:
- byte: strobe = 1 << a; data replicated on all 4 lanes.
- half: strobe = 0011 << a[1]*2; data replicated on both halves; a[0] ignored.
- word: strobe = 1111; a ignored.
REQ-029 Load extraction: the word is shifted right by 8*a (half uses a[1] only), truncated to the access size, then sign-extended if mem_signed is high, else zero-extended.
REQ-030 Store coherence: a MEM store completing to word address W clears the fetch latch valid bit if the latch address word equals W.
REQ-031 Any MEM completion of a kind or address different from the record overwrites the record; the record is never cleared except by reset.
REQ-032 Minimum latency with ext_ready high on the first ext_valid cycle:
- ext_valid is high in cycle N+1 after a miss in cycle N.
- fetch_ready / mem_ready is high in cycle N+2.

Reset
REQ-033 While reset is high, and immediately on its assertion:
- ext_valid = 0, ext_write_strobe = 0, ext_instruction = 0, ext_address = 0, ext_write_data = 0.
- FSM = IDLE.
- Fetch latch and completion record valid bits = 0.
- fetch_ready = 0.
- mem_ready = 1 when no request, else 0.
REQ-034 Reset mid-transaction abandons it; no latch or record is updated, and the first request after reset release is issued fresh.

Verification
REQ-035 Fetch miss: reset release, fetch_address = 0x100, ext_ready = 1, ext_read_data = 0x00000013 -> ext_valid high for 1 cycle with ext_address = 0x100 and ext_instruction = 1; two cycles later fetch_ready = 1, fetch_data = 0x13.
REQ-036 Signed byte load: mem_load = 1, mem_address = 0x203, size = 0, signed = 1, ext_read_data = 0x80FFFFFF -> ext_write_strobe = 0000, mem_load_data = 0xFFFFFF80; repeat with signed = 0 -> 0x00000080.
REQ-037 Half store: mem_address = 0x402, size = 1, data = 0x0000BEEF -> strobe = 1100, ext_write_data = 0xBEEFBEEF, mem_ready high after completion, only one ext transaction.
REQ-038 Arbitration and stall: fetch miss and load miss in the same IDLE cycle, ext_ready delayed 3 cycles -> MEM issued first with outputs stable for all 4 cycles; FETCH follows.
REQ-039 Coherence: fetch 0x300 latched, then word store to 0x300 -> fetch_ready drops and a new FETCH to 0x300 is issued.
REQ-040 Reset mid-FETCH: reset asserted while ext_valid = 1 -> ext_valid = 0 asynchronously; after release the same address is refetched.
